elelock_multi: RTL and testbench

Parametrised multi-digit electronic lock for the door-controller subsystem. Decodes a one-hot 10-key pad and accepts one digit per key press, on the release-to-press edge. Compares a DIGITS-long entry sequence against a compile-time code and drives the lock solenoid. Repeated wrong codes put it into an alarmed lockout.

---
 rtl/elelock_multi.sv | 171 +++++++++++++++++
 tb/tb_elelock_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/elelock_multi.sv
// Multi-digit keypad lock with consecutive-failure lockout.
// Optional OPEN-state auto-relock is built when ELELOCK_AUTOLOCK_EN is defined.
module elelock_multi #(
   parameter int unsigned          DIGITS       = 4,
   parameter logic [4*DIGITS-1:0]  CODE         = 16'h1234,
   parameter int unsigned          MAX_FAIL     = 3,
   parameter int unsigned          LOCKOUT_CYC  = 1000,
   parameter int unsigned          AUTOLOCK_CYC = 500
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [9:0]                      tenkey,
   input  logic                            close,
   output logic                            lock,
   output logic                            alarm,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

   localparam int unsigned FW = $clog2(MAX_FAIL + 1);
   localparam int unsigned IW = $clog2(DIGITS + 1);
   localparam int unsigned TW = $clog2(LOCKOUT_CYC + 1);

   if (DIGITS < 1 || DIGITS > 8 || MAX_FAIL < 1 || LOCKOUT_CYC < 1 || AUTOLOCK_CYC < 1) begin : g_bad_param
      $error("elelock_multi: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_LOCKED,
      S_OPEN,
      S_LOCKOUT
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [9:0]      key_q;
   logic [9:0]      key_p;
   logic [IW-1:0]   idx;
   logic            err;
   logic [TW-1:0]   timer;

   logic            press;
   logic [3:0]      digit;
   logic [3:0]      exp_digit;
   logic            last;
   logic            accept;
   logic            entry_done;
   logic            entry_ok;
   logic            mismatch;
   logic [FW-1:0]   fail_inc;
   logic            to_lockout;
   logic            timer_zero;

`ifdef ELELOCK_AUTOLOCK_EN
   localparam int unsigned OW = $clog2(AUTOLOCK_CYC + 1);
   logic [OW-1:0]   open_cnt;
   logic            autolock;

   // Held at zero outside OPEN, so it always starts from zero on entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         open_cnt <= '0;
      end else if (state != S_OPEN) begin
         open_cnt <= '0;
      end else begin
         open_cnt <= open_cnt + OW'(1);
      end
   end

   assign autolock = (open_cnt == OW'(AUTOLOCK_CYC - 1));
`endif

   always_comb begin
      digit     = '0;
      exp_digit = '0;
      for (int unsigned k = 0; k < 10; k++) begin
         if (key_q[k]) digit = 4'(k);
      end
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) exp_digit = CODE[4*(DIGITS-1-i) +: 4];
      end
   end

   assign press      = $onehot(key_q) && (key_p == '0);
   assign last       = (idx == IW'(DIGITS - 1));
   assign accept     = (state == S_LOCKED) && press && !close;
   assign mismatch   = (digit != exp_digit);
   assign entry_done = accept && last;
   assign entry_ok   = !err && !mismatch;
   assign fail_inc   = fail_cnt + FW'(1);
   assign to_lockout = (fail_inc == FW'(MAX_FAIL));
   assign timer_zero = (timer == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_LOCKED;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_LOCKED: begin
            if (entry_done) begin
               if (entry_ok)        state_n = S_OPEN;
               else if (to_lockout) state_n = S_LOCKOUT;
            end
         end
         S_OPEN: begin
            if (close) state_n = S_LOCKED;
`ifdef ELELOCK_AUTOLOCK_EN
            else if (autolock) state_n = S_LOCKED;
`endif
         end
         S_LOCKOUT: begin
            if (timer_zero) state_n = S_LOCKED;
         end
         default: state_n = S_LOCKED;
      endcase
   end

   always_comb begin
      lock  = 1'b1;
      alarm = 1'b0;
      case (state)
         S_OPEN:    lock  = 1'b0;
         S_LOCKOUT: alarm = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q    <= '0;
         key_p    <= '0;
         idx      <= '0;
         err      <= 1'b0;
         fail_cnt <= '0;
         timer    <= '0;
      end else begin
         key_q <= tenkey;
         key_p <= key_q;
         if (state == S_LOCKED) begin
            // close has priority over a press committed in the same cycle
            if (close) begin
               idx <= '0;
               err <= 1'b0;
            end else if (accept) begin
               if (last) begin
                  idx <= '0;
                  err <= 1'b0;
                  if (entry_ok) begin
                     fail_cnt <= '0;
                  end else begin
                     fail_cnt <= fail_inc;
                     if (to_lockout) timer <= TW'(LOCKOUT_CYC - 1);
                  end
               end else begin
                  idx <= idx + IW'(1);
                  err <= err | mismatch;
               end
            end
         end else if (state == S_LOCKOUT) begin
            if (timer_zero) fail_cnt <= '0;
            else            timer    <= timer - TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_elelock_multi.sv
// Directed bench for elelock_multi at default parameters.
// Follows ELELOCK_AUTOLOCK_EN to choose the OPEN-timeout expectations.
module tb_elelock_multi;

   logic       clk;
   logic       rst_n;
   logic [9:0] tenkey;
   logic       close;
   logic       lock;
   logic       alarm;
   logic [1:0] fail_cnt;

   int errors = 0;
   int checks = 0;
   int acnt;

   elelock_multi dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tenkey   (tenkey),
      .close    (close),
      .lock     (lock),
      .alarm    (alarm),
      .fail_cnt (fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press_key(input int k);
      tenkey = 10'(1 << k);
      step();
      tenkey = '0;
      step();
   endtask

   task automatic enter(input int a, input int b, input int c, input int d);
      press_key(a);
      press_key(b);
      press_key(c);
      press_key(d);
   endtask

   task automatic relock();
      close = 1'b1;
      step();
      close = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      tenkey = '0;
      close  = 1'b0;
      repeat (3) step();
      check("reset_lock", 32'(lock), 1);
      check("reset_alarm", 32'(alarm), 0);
      check("reset_fail", 32'(fail_cnt), 0);
      rst_n = 1'b1;
      step();

      // correct code, with unlock latency on the final digit
      press_key(1);
      press_key(2);
      press_key(3);
      tenkey = 10'(1 << 4);
      step();
      check("t1_lock_after_sample", 32'(lock), 1);
      tenkey = '0;
      step();
      check("t1_unlock", 32'(lock), 0);
      check("t1_fail", 32'(fail_cnt), 0);
      close = 1'b1;
      step();
      check("t1_close_lock", 32'(lock), 1);
      close = 1'b0;

      // held key counts once
      tenkey = 10'(1 << 1);
      repeat (10) step();
      tenkey = '0;
      step();
      press_key(2);
      press_key(3);
      check("t2_before_last", 32'(lock), 1);
      press_key(4);
      check("t2_hold_unlock", 32'(lock), 0);
      relock();

      // multi-key pattern ignored
      tenkey = 10'b0000000110;
      step();
      tenkey = '0;
      step();
      enter(1, 2, 3, 4);
      check("t3_multikey_unlock", 32'(lock), 0);
      check("t3_fail", 32'(fail_cnt), 0);
      relock();

      // wrong entries into lockout
      enter(1, 2, 3, 5);
      check("t4_fail1", 32'(fail_cnt), 1);
      check("t4_lock1", 32'(lock), 1);
      check("t4_alarm1", 32'(alarm), 0);
      enter(1, 2, 3, 5);
      check("t4_fail2", 32'(fail_cnt), 2);
      press_key(1);
      press_key(2);
      press_key(3);
      tenkey = 10'(1 << 5);
      step();
      check("t4_alarm_not_yet", 32'(alarm), 0);
      tenkey = '0;
      step();
      check("t4_alarm_on", 32'(alarm), 1);
      check("t4_fail3", 32'(fail_cnt), 3);
      acnt = 1;
      for (int i = 1; i < 1000; i++) begin
         tenkey = (i % 2 == 1) ? 10'(1 << ((i / 2) % 3 + 1)) : 10'b0;
         close  = (i % 7 == 0);
         step();
         if (alarm) acnt++;
      end
      tenkey = '0;
      close  = 1'b0;
      check("t4_alarm_cycles", 32'(acnt), 1000);
      check("t4_lock_during", 32'(lock), 1);
      step();
      check("t4_alarm_off", 32'(alarm), 0);
      check("t4_fail_cleared", 32'(fail_cnt), 0);
      check("t4_lock_after", 32'(lock), 1);
      enter(1, 2, 3, 4);
      check("t4_unlock_after", 32'(lock), 0);
      relock();

      // close aborts partial entry; fail_cnt preserved
      enter(9, 9, 9, 9);
      check("t5_fail_pre", 32'(fail_cnt), 1);
      press_key(1);
      press_key(2);
      relock();
      check("t5_fail_kept", 32'(fail_cnt), 1);
      press_key(1);
      press_key(2);
      tenkey = 10'(1 << 3);
      step();
      tenkey = '0;
      close  = 1'b1;
      step();
      close  = 1'b0;
      enter(1, 2, 3, 4);
      check("t5_abort_unlock", 32'(lock), 0);
      check("t5_fail_zero", 32'(fail_cnt), 0);

`ifdef ELELOCK_AUTOLOCK_EN
      repeat (499) step();
      check("t6_autolock_pre", 32'(lock), 0);
      step();
      check("t6_autolock", 32'(lock), 1);
`else
      repeat (2000) step();
      check("t6_stay_open", 32'(lock), 0);
      relock();
      check("t6_close_lock", 32'(lock), 1);
`endif

      // reset mid-lockout
      step();
      enter(5, 5, 5, 5);
      enter(5, 5, 5, 5);
      enter(5, 5, 5, 5);
      check("t7_alarm_on", 32'(alarm), 1);
      repeat (10) step();
      rst_n = 1'b0;
      #1;
      check("t7_rst_alarm", 32'(alarm), 0);
      check("t7_rst_lock", 32'(lock), 1);
      check("t7_rst_fail", 32'(fail_cnt), 0);
      step();
      rst_n = 1'b1;
      step();
      enter(1, 2, 3, 4);
      check("t7_unlock_after_rst", 32'(lock), 0);

      // reset mid-entry discards digits already taken
      relock();
      press_key(1);
      press_key(2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      enter(1, 2, 3, 4);
      check("t8_unlock_after_rst", 32'(lock), 0);
      check("t8_fail", 32'(fail_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
